// File: rtl/mips_pkg.sv
// Shared pipeline constants: divide occupancy default, forwarding select encodings
// and the divide-tracker state type.
package mips_pkg;

    localparam int unsigned DIV_CYCLES_DEF = 32;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_t;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_t;

    // E-stage operand select; M-stage result wins over W when both match.
    function automatic fwd_t fwd_e_sel(
        input logic [4:0] src,
        input logic [4:0] wreg_m,
        input logic       rw_m,
        input logic [4:0] wreg_w,
        input logic       rw_w
    );
        if (src != 5'd0 && src == wreg_m && rw_m)
            return FWD_MEM;
        else if (src != 5'd0 && src == wreg_w && rw_w)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle; the pipeline is the master, the hazard unit the slave.
interface hazard_ctrl_if;

    logic [4:0] rsD, rtD, rsE, rtE;
    logic [4:0] writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic       branchD, jrD, divstartE;

    logic       forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic       stallF, stallD, stallE, stallM, stallW;
    logic       flushE, flushM, flushW;
    logic       divdoneE;

    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
               branchD, jrD, divstartE,
        input  forwardAD, forwardBD, forwardAE, forwardBE,
               stallF, stallD, stallE, stallM, stallW,
               flushE, flushM, flushW, divdoneE
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
               branchD, jrD, divstartE,
        output forwardAD, forwardBD, forwardAE, forwardBE,
               stallF, stallD, stallE, stallM, stallW,
               flushE, flushM, flushW, divdoneE
    );

endinterface

// File: rtl/hazard_divcnt.sv
// Multi-cycle divide tracker: holds the divide in E for DIV_CYCLES stall cycles
// followed by one divdoneE cycle.
module hazard_divcnt
    import mips_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic divstartE,
    output logic divstall,
    output logic divdoneE
);

    div_state_t r_state, w_state_nxt;
    logic [5:0] r_cnt, w_cnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        divstall    = 1'b0;
        divdoneE    = 1'b0;
        unique case (r_state)
            DIV_IDLE: begin
                if (divstartE) begin
                    w_state_nxt = DIV_BUSY;
                    w_cnt_nxt   = 6'(DIV_CYCLES - 1);
                    divstall    = 1'b1;
                end
            end
            DIV_BUSY: begin
                // divstartE is deliberately not looked at here, even on the done cycle
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 6'd1;
                    divstall  = 1'b1;
                end else begin
                    w_state_nxt = DIV_IDLE;
                    divdoneE    = 1'b1;
                end
            end
            default: w_state_nxt = DIV_IDLE;
        endcase
        if (!rst) begin
            divstall = 1'b0;
            divdoneE = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding selects plus load-use, branch and divide stall/flush control.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);

    logic w_lwstall, w_branchstall, w_divstall, w_divdone, w_fetchstall;
    logic w_brsrc_e, w_brsrc_m;
    fwd_t w_fwd_ae, w_fwd_be;

    hazard_divcnt #(
        .DIV_CYCLES(DIV_CYCLES)
    ) u_divcnt (
        .clk      (clk),
        .rst      (rst),
        .divstartE(hz.divstartE),
        .divstall (w_divstall),
        .divdoneE (w_divdone)
    );

    always_comb begin
        w_fwd_ae = fwd_e_sel(hz.rsE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
        w_fwd_be = fwd_e_sel(hz.rtE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);

        w_lwstall     = hz.memtoregE & ((hz.rtE == hz.rsD) | (hz.rtE == hz.rtD));
        w_brsrc_e     = hz.regwriteE & ((hz.writeregE == hz.rsD) | (hz.writeregE == hz.rtD));
        w_brsrc_m     = hz.memtoregM & ((hz.writeregM == hz.rsD) | (hz.writeregM == hz.rtD));
        w_branchstall = (hz.branchD | hz.jrD) & (w_brsrc_e | w_brsrc_m);
        w_fetchstall  = w_lwstall | w_branchstall | w_divstall;

        hz.forwardAD = 1'b0;
        hz.forwardBD = 1'b0;
        hz.forwardAE = FWD_RF;
        hz.forwardBE = FWD_RF;
        hz.stallF    = 1'b0;
        hz.stallD    = 1'b0;
        hz.stallE    = 1'b0;
        hz.stallM    = 1'b0;
        hz.stallW    = 1'b0;
        hz.flushE    = 1'b0;
        hz.flushM    = 1'b0;
        hz.flushW    = 1'b0;
        hz.divdoneE  = 1'b0;

        // Everything stays at zero while reset is held, whatever the inputs say.
        if (rst) begin
            hz.forwardAD = (hz.rsD != 5'd0) & (hz.rsD == hz.writeregM) & hz.regwriteM;
            hz.forwardBD = (hz.rtD != 5'd0) & (hz.rtD == hz.writeregM) & hz.regwriteM;
            hz.forwardAE = w_fwd_ae;
            hz.forwardBE = w_fwd_be;
            hz.stallF    = w_fetchstall;
            hz.stallD    = w_fetchstall;
            hz.stallE    = w_divstall;
            hz.flushM    = w_divstall;
            hz.flushE    = (w_lwstall | w_branchstall) & ~w_divstall;
            hz.divdoneE  = w_divdone;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32; divide occupancy in E stage, legal range 2..63.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports rsD, rtD, rsE, rtE  input  5 each  source register numbers in the D and E stages.
REQ-005 SHALL have ports writeregE, writeregM, writeregW  input  5 each  destination register numbers in E, M and W.
REQ-006 SHALL have ports regwriteE, regwriteM, regwriteW, memtoregE, memtoregM  input  1 each  pipeline write-control bits.
REQ-007 SHALL have ports branchD, jrD  input  1 each  the D-stage instruction resolves a branch or register jump.
REQ-008 SHALL have port divstartE  input  1  the E-stage instruction is a multi-cycle divide.
REQ-009 SHALL have ports forwardAD, forwardBD  output  1 each  D-stage compare operand taken from the M-stage result.
REQ-010 SHALL have ports forwardAE, forwardBE  output  2 each  E-stage ALU operand select.
REQ-011 SHALL have ports stallF, stallD, stallE, stallM, stallW, flushE, flushM, flushW  output  1 each  pipeline register control.
REQ-012 SHALL have port divdoneE  output  1  the divide result is valid in E this cycle.

Function
REQ-013 forwardAE SHALL be 10 when rsE!=0, rsE==writeregM and regwriteM; otherwise 01 when rsE!=0, rsE==writeregW and regwriteW; otherwise 00. forwardBE SHALL follow the same rule using rtE. The M stage SHALL take priority over W.
REQ-014 forwardAD SHALL be rsD!=0 & rsD==writeregM & regwriteM. forwardBD SHALL follow the same rule using rtD.
REQ-015 lwstall SHALL be memtoregE & (rtE==rsD | rtE==rtD).
REQ-016 branchstall SHALL be (branchD|jrD) & ((regwriteE & writeregE in {rsD,rtD}) | (memtoregM & writeregM in {rsD,rtD})).
REQ-017 The divide tracker SHALL have the states IDLE and BUSY and a 6-bit down-counter cnt.
- IDLE & divstartE: next state BUSY, cnt<=DIV_CYCLES-1.
- BUSY & cnt!=0: cnt<=cnt-1.
- BUSY & cnt==0: next state IDLE.
REQ-018 divstall SHALL be (IDLE & divstartE) | (BUSY & cnt!=0). divdoneE SHALL be BUSY & cnt==0. A divide therefore stays in E for DIV_CYCLES+1 cycles.
REQ-019 divstartE SHALL be ignored while in BUSY, including during the divdoneE cycle.
REQ-020 The outputs SHALL be stallF = stallD = lwstall | branchstall | divstall, stallE = divstall and flushM = divstall.
REQ-021 flushE SHALL be (lwstall | branchstall) & ~divstall; divstall has priority and the E stage is never flushed while it holds a divide.
REQ-022 stallM, stallW and flushW SHALL be constant 0.
REQ-023 Forwarding and stall outputs SHALL be combinational from the current inputs and state, with zero-cycle latency.

Reset
REQ-024 While rst=0, the block SHALL hold state IDLE and cnt=0.
REQ-025 While rst=0, every output SHALL be forced to 0, regardless of the other inputs.
REQ-026 Reset asserted mid-divide SHALL abort the divide immediately. After release the block SHALL be in IDLE and a held divstartE SHALL restart a full count.

Structure
REQ-027 DIV_CYCLES default and the forwarding encodings FWD_RF=00, FWD_WB=01, FWD_MEM=10 SHALL live in the shared package mips_pkg.
REQ-028 The divide state machine and counter SHALL be the sub-module hazard_divcnt, with ports clk, rst, divstartE, divstall, divdoneE.
REQ-029 All remaining logic SHALL be combinational in hazard_ctrl.

Verification
REQ-030 rsE=5, writeregM=5, regwriteM=1, writeregW=5, regwriteW=1 -> forwardAE=10. Set regwriteM=0 -> forwardAE=01. Set rsE=0 -> forwardAE=00.
REQ-031 memtoregE=1, rtE=8, rsD=8 -> stallF=stallD=flushE=1 for one cycle, stallE=0. Set memtoregE=0 -> all four signals 0.
REQ-032 branchD=1, rsD=3, regwriteE=1, writeregE=3 -> stallD=flushE=1. In the next cycle, with memtoregM=0 and writeregM=3 -> no stall, forwardAD=1.
REQ-033 DIV_CYCLES=32, divstartE held high -> stallE=flushM=1 for exactly 32 cycles, then divdoneE=1 and stallE=0 on cycle 33, then state returns to IDLE.
REQ-034 Divide busy and lwstall true together -> stallF=stallD=stallE=1, flushE=0.
REQ-035 rst pulsed low at cycle 10 of a divide -> all outputs 0 during reset; after release with divstartE=1, the stall lasts a full 32 cycles.
